// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM states and op-class helpers for alu_mdu_seq
package alu_pkg;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'b00000,
    ALU_SUB    = 5'b00001,
    ALU_OR     = 5'b00010,
    ALU_AND    = 5'b00011,
    ALU_SLL    = 5'b00100,
    ALU_SLT    = 5'b00101,
    ALU_SLTU   = 5'b00110,
    ALU_XOR    = 5'b00111,
    ALU_SRL    = 5'b01000,
    ALU_SRA    = 5'b01001,
    ALU_PASSB  = 5'b01010,
    ALU_MUL    = 5'b10000,
    ALU_MULH   = 5'b10001,
    ALU_MULHSU = 5'b10010,
    ALU_MULHU  = 5'b10011,
    ALU_DIV    = 5'b10100,
    ALU_DIVU   = 5'b10101,
    ALU_REM    = 5'b10110,
    ALU_REMU   = 5'b10111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } alu_state_e;

  function automatic logic is_mul(input logic [4:0] op);
    return op[4:2] == 3'b100;
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return op[4:2] == 3'b101;
  endfunction

endpackage

// File: rtl/alu_mdu_seq_if.sv
// rtl/alu_mdu_seq_if.sv - request/result handshake bundle of alu_mdu_seq
interface alu_mdu_seq_if #(parameter int XLEN = 32) ();
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      alu_op;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_out;
  logic            busy;

  modport master (
    output flush, in_valid, alu_op, A, B, out_ready,
    input  in_ready, out_valid, alu_out, busy
  );

  modport slave (
    input  flush, in_valid, alu_op, A, B, out_ready,
    output in_ready, out_valid, alu_out, busy
  );
endinterface

// File: rtl/alu_base_comb.sv
// rtl/alu_base_comb.sv - combinational evaluator for the single-cycle base ops
module alu_base_comb
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);
  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_OR:    y = a | b;
      ALU_AND:   y = a & b;
      ALU_SLL:   y = a << shamt;
      ALU_SLT:   y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:  y = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:   y = a ^ b;
      ALU_SRL:   y = a >> shamt;
      ALU_SRA:   y = $unsigned($signed(a) >>> shamt);
      ALU_PASSB: y = b;
      default:   y = '0;
    endcase
  end
endmodule

// File: rtl/alu_mdu_seq.sv
// rtl/alu_mdu_seq.sv - execute-stage ALU with iterative multiply and restoring divide
module alu_mdu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         rst,
  alu_mdu_seq_if.slave ifc
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0]  LAST    = SHW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  alu_state_e      state_q, state_d;
  alu_op_e         op_q, op_d, req_op;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d, res_q, res_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic            neg_q, neg_d, neg_r_q, neg_r_d;

  logic [XLEN-1:0]   base_y, a_mag, b_mag, hi_n, lo_n, quo_f, rem_f;
  logic [XLEN:0]     add_x, add_y;
  logic              add_cin;
  logic [XLEN+1:0]   add_s;
  logic [2*XLEN-1:0] prod_f;
  logic              take, a_sgn, b_sgn, a_neg, b_neg;

  assign req_op = alu_op_e'(ifc.alu_op);

  alu_base_comb #(.XLEN(XLEN)) u_base (
    .op (req_op),
    .a  (ifc.A),
    .b  (ifc.B),
    .y  (base_y)
  );

  assign ifc.in_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE && ifc.out_ready);
  assign ifc.out_valid = (state_q == ST_DONE);
  assign ifc.busy      = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign ifc.alu_out   = res_q;
  assign take          = ifc.in_valid && ifc.in_ready && !ifc.flush;

  // Iterations run on magnitudes; the result sign is restored in the last step.
  assign a_sgn = req_op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
  assign b_sgn = req_op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
  assign a_neg = a_sgn && ifc.A[XLEN-1];
  assign b_neg = b_sgn && ifc.B[XLEN-1];
  assign a_mag = a_neg ? -ifc.A : ifc.A;
  assign b_mag = b_neg ? -ifc.B : ifc.B;

  // One adder: hi+mcand when multiplying, {rem,next bit}-divisor when dividing.
  always_comb begin
    add_x   = {1'b0, hi_q};
    add_y   = lo_q[0] ? {1'b0, mcand_q} : '0;
    add_cin = 1'b0;
    if (state_q == ST_DIV) begin
      add_x   = {hi_q, lo_q[XLEN-1]};
      add_y   = ~{1'b0, mcand_q};
      add_cin = 1'b1;
    end
  end

  assign add_s = {1'b0, add_x} + {1'b0, add_y} + {{(XLEN+1){1'b0}}, add_cin};

  always_comb begin
    if (state_q == ST_DIV) begin
      hi_n = add_s[XLEN+1] ? add_s[XLEN-1:0] : {hi_q[XLEN-2:0], lo_q[XLEN-1]};
      lo_n = {lo_q[XLEN-2:0], add_s[XLEN+1]};
    end else begin
      hi_n = add_s[XLEN:1];
      lo_n = {add_s[0], lo_q[XLEN-1:1]};
    end
  end

  assign prod_f = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
  assign quo_f  = neg_q ? -lo_n : lo_n;
  assign rem_f  = neg_r_q ? -hi_n : hi_n;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    neg_r_d = neg_r_q;
    res_d   = res_q;
    if (ifc.flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_MUL, ST_DIV: begin
          hi_d  = hi_n;
          lo_d  = lo_n;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = ST_DONE;
            cnt_d   = '0;
            if (state_q == ST_MUL)
              res_d = (op_q == ALU_MUL) ? prod_f[XLEN-1:0] : prod_f[2*XLEN-1:XLEN];
            else
              res_d = (op_q == ALU_DIV || op_q == ALU_DIVU) ? quo_f : rem_f;
          end
        end
        default: begin
          if (take) begin
            op_d    = req_op;
            hi_d    = '0;
            cnt_d   = '0;
            neg_d   = a_neg ^ b_neg;
            neg_r_d = a_neg;
            if (is_mul(req_op)) begin
              state_d = ST_MUL;
              lo_d    = b_mag;
              mcand_d = a_mag;
            end else if (is_div(req_op)) begin
              // Zero divisor and signed overflow have fixed answers; skip the iteration.
              if (ifc.B == '0) begin
                state_d = ST_DONE;
                res_d   = (req_op == ALU_DIV || req_op == ALU_DIVU) ? '1 : ifc.A;
              end else if (b_sgn && ifc.A == MIN_NEG && ifc.B == '1) begin
                state_d = ST_DONE;
                res_d   = (req_op == ALU_DIV) ? ifc.A : '0;
              end else begin
                state_d = ST_DIV;
                lo_d    = a_mag;
                mcand_d = b_mag;
              end
            end else begin
              state_d = ST_DONE;
              res_d   = base_y;
            end
          end else if (state_q == ST_DONE && ifc.out_ready) begin
            state_d = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= ALU_ADD;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      neg_r_q <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      neg_r_q <= neg_r_d;
      res_q   <= res_d;
    end
  end
endmodule

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
- Parametrised, multi-cycle successor to the single-cycle integer ALU, sitting in the execute stage.
- Performs the RV32/64 base ALU ops in one registered cycle.
- Adds the M-extension multiply/divide/remainder ops via an iterative shift-add multiplier and a restoring divider.
- Uses a valid/ready handshake on both sides so the core can stall on long ops.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- SHW, $clog2(XLEN), shift-amount width (derived; not overridable).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous abort of any in-flight op.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- alu_op  in  5  operation select.
- A  in  XLEN  operand A (rs1).
- B  in  XLEN  operand B (rs2/imm).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- alu_out  out  XLEN  result.
- busy  out  1  MUL or DIV iteration in progress.

Behaviour:
- Reset state (asynchronous, rst=1): state=IDLE, out_valid=0, alu_out=0, busy=0, all iteration registers 0.
- in_ready is combinational: 1 in IDLE, or in DONE when out_ready=1. It is therefore 1 out of reset.
- A request is accepted when in_valid && in_ready. Operands and op are sampled only on acceptance.
- Op encoding: base ops 00000 ADD, 00001 SUB, 00010 OR, 00011 AND, 00100 SLL, 00101 SLT, 00110 SLTU, 00111 XOR, 01000 SRL, 01001 SRA, 01010 PASSB.
- M ops: 10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU, 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
- Any other code produces alu_out=0 with normal 1-cycle latency.
- Shifts use B[SHW-1:0] only; upper bits of B are ignored.
- SLT/SLTU results are zero-extended to XLEN.
- Arithmetic wraps modulo 2^XLEN; there are no flags.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: accept a base op -> DONE, result registered. Accept MUL* -> MUL. Accept DIV*/REM* -> DIV, unless a special case applies (see below).
  - MUL: XLEN iterations on operand magnitudes, sign applied in the last step, then DONE. MUL returns the low XLEN bits; MULH* return the high XLEN bits.
  - DIV: XLEN restoring iterations, signs fixed in the last step, then DONE.
  - DONE: out_valid=1 and alu_out held stable until out_ready. If out_ready && in_valid, the new request is accepted in the same cycle (back-to-back). If out_ready && !in_valid -> IDLE.
- Latency from acceptance to out_valid: base ops 1 cycle; MUL* and DIV*/REM* XLEN+1 cycles.
- Sustained throughput: 1 base op per cycle.
- busy=1 exactly while in MUL or DIV; in_ready=0 during those states.
- Divide special cases are resolved in IDLE with 1-cycle latency:
  - Divisor 0: quotient = all ones; remainder = A.
  - Signed overflow (A = most-negative, B = -1): quotient = A; remainder = 0.
- flush (priority below rst, above everything else): next cycle state=IDLE, out_valid=0, busy=0. A same-cycle request is not accepted. alu_out keeps its last value.
- Asynchronous reset mid-iteration discards the op. There is no output glitch requirement beyond out_valid=0.

Decomposition:
- Package alu_pkg holds:
  - alu_op_e, a 5-bit enum with the codes above.
  - Helpers is_mul(op) and is_div(op).
  - alu_state_e enum.
- One sub-module, alu_base_comb: purely combinational base-op evaluator, parametrised by XLEN, instantiated once and registered in alu_mdu_seq.
- Multiply and divide iteration logic stays inline in alu_mdu_seq, sharing one XLEN+1-bit adder.

Test Plan:
- Base ops, XLEN=32, out_ready tied 1: ADD 7,5 ->12; SUB 5,7 -> 0xFFFFFFFE; SRA 0x80000000,B=0x21 -> 0xC0000000 (shamt=1); SLT 0xFFFFFFFF,1 ->1. Back-to-back, one result per cycle, latency 1.
- MULH -3 x 5 -> 0xFFFFFFFF and MULHU 0xFFFFFFFF x 2 -> 1; out_valid exactly 33 cycles after acceptance, busy=1 for 32 cycles, in_ready=0 meanwhile.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF; REM 0x80000000/-1 -> 0 with 1-cycle latency.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> alu_out stable, in_ready=0, no new request accepted; release -> result consumed exactly once.
- flush at iteration 10 of DIV -> out_valid never rises for that op, in_ready=1 next cycle. Async rst mid-MUL -> all outputs at reset values immediately.
- XLEN=64 build: MUL 0xFFFFFFFFFFFFFFFF x 0xFFFFFFFFFFFFFFFF -> 1, latency 65 cycles; SLL by B=0x41 -> shift by 1.
